// File: rtl/heap_cmd_sequencer_pkg.sv
// Shared encodings for the heap command sequencer: command opcodes, heap opcodes,
// sequencer states and the queued command entry layout.
package heap_cmd_sequencer_pkg;

  localparam int unsigned CMD_DATA_W  = 32;
  localparam int unsigned CMD_OP_W    = 2;
  localparam int unsigned CMD_ENTRY_W = CMD_DATA_W + CMD_OP_W;
  localparam int unsigned HEAP_OP_W   = 5;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_ILLEGAL = 2'd0,
    CMD_INSERT  = 2'd1,
    CMD_EXTRACT = 2'd2,
    CMD_PEEK    = 2'd3
  } cmd_op_e;

  typedef enum logic [HEAP_OP_W-1:0] {
    HEAP_NOP     = 5'd0,
    HEAP_INSERT  = 5'd1,
    HEAP_EXTRACT = 5'd2
  } heap_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

  typedef struct packed {
    cmd_op_e               op;
    logic [CMD_DATA_W-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/heap_cmd_fifo.sv
// In-order command queue between the upstream handshake and the sequencer FSM.
// Simultaneous push and pop both take effect; pointers wrap at DEPTH.
module heap_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/heap_cmd_sequencer.sv
// Queues upstream heap commands and plays them one at a time against an external
// heap, checking capacity/occupancy first and returning one response per command.
//
// state | meaning
// IDLE  | waiting for a queued command
// CHECK | pop head command, judge it against heap_size, latch response data
// ISSUE | heap_enable strobe for one cycle with registered opcode/operand
// WAIT  | HEAP_LAT cycles for the heap to settle
// RESP  | hold rsp_valid/rsp_data/rsp_err until rsp_ready
module heap_cmd_sequencer
  import heap_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HEAP_CAP   = 31,
  parameter int unsigned HEAP_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        heap_enable,
  output logic [4:0]  heap_operation,
  output logic [31:0] heap_value,
  input  logic [4:0]  heap_size,
  input  logic [31:0] heap_top,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned LAT_W = (HEAP_LAT > 1) ? $clog2(HEAP_LAT) : 1;

  seq_state_e        state_q;
  logic              ready_en_q;
  logic [LAT_W-1:0]  wait_cnt_q;
  logic              heap_enable_q;
  heap_op_e          heap_op_q;
  logic [31:0]       heap_value_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  cmd_entry_t        push_entry, head;
  logic              cmd_reject;

  // ready_en_q keeps cmd_ready low through reset and for the edge that releases it.
  assign cmd_ready  = ready_en_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == ST_CHECK);
  assign push_entry = '{op: cmd_op_e'(cmd_op), data: cmd_data};

  heap_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_ENTRY_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    cmd_reject = 1'b0;
    case (head.op)
      CMD_INSERT:            cmd_reject = (32'(heap_size) >= HEAP_CAP);
      CMD_EXTRACT, CMD_PEEK: cmd_reject = (heap_size == '0);
      default:               cmd_reject = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ready_en_q    <= 1'b0;
      wait_cnt_q    <= '0;
      heap_enable_q <= 1'b0;
      heap_op_q     <= HEAP_NOP;
      heap_value_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (cmd_reject) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (head.op == CMD_PEEK) begin
            rsp_data_q  <= heap_top;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (head.op == CMD_EXTRACT) begin
            rsp_data_q    <= heap_top;
            rsp_err_q     <= 1'b0;
            heap_enable_q <= 1'b1;
            heap_op_q     <= HEAP_EXTRACT;
            heap_value_q  <= '0;
            state_q       <= ST_ISSUE;
          end else begin
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            heap_enable_q <= 1'b1;
            heap_op_q     <= HEAP_INSERT;
            heap_value_q  <= head.data;
            state_q       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          heap_enable_q <= 1'b0;
          heap_op_q     <= HEAP_NOP;
          heap_value_q  <= '0;
          if (HEAP_LAT == 0) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= LAT_W'(HEAP_LAT - 1);
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - LAT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign heap_enable    = heap_enable_q;
  assign heap_operation = heap_op_q;
  assign heap_value     = heap_value_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_heap_cmd_sequencer.sv
// Directed bench for heap_cmd_sequencer with a sorted-queue stand-in for the heap.
module tb_heap_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        heap_enable;
  logic [4:0]  heap_operation;
  logic [31:0] heap_value;
  logic [4:0]  heap_size;
  logic [31:0] heap_top;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  int unsigned heap_q[$];
  logic        size_ovr_en = 1'b0;
  logic [4:0]  size_ovr = 5'd0;
  logic [4:0]  model_size = 5'd0;
  logic [31:0] model_top = 32'd0;

  int unsigned stb_op[$];
  int unsigned stb_val[$];
  int unsigned stb_cyc[$];
  int unsigned rsp_d[$];
  int unsigned rsp_e[$];
  int          bad_idle = 0;

  assign heap_size = size_ovr_en ? size_ovr : model_size;
  assign heap_top  = model_top;

  heap_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .HEAP_CAP   (31),
    .HEAP_LAT   (2)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .heap_enable    (heap_enable),
    .heap_operation (heap_operation),
    .heap_value     (heap_value),
    .heap_size      (heap_size),
    .heap_top       (heap_top),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Heap stand-in and observation logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (heap_enable) begin
      stb_op.push_back(32'(heap_operation));
      stb_val.push_back(heap_value);
      stb_cyc.push_back(cyc);
      if (heap_operation == 5'd1) begin
        heap_q.push_back(heap_value);
        heap_q.sort();
      end else if (heap_operation == 5'd2 && heap_q.size() > 0) begin
        void'(heap_q.pop_front());
      end
    end else if (heap_operation != 5'd0 || heap_value != 32'd0) begin
      bad_idle++;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_d.push_back(rsp_data);
      rsp_e.push_back(32'(rsp_err));
    end
    model_size = 5'(heap_q.size());
    model_top  = (heap_q.size() > 0) ? heap_q[0] : 32'd0;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    stb_op.delete();
    stb_val.delete();
    stb_cyc.delete();
    rsp_d.delete();
    rsp_e.delete();
    bad_idle = 0;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] data);
    int budget = 60;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (!cmd_ready) $display("FAIL send_accept: cmd_ready got %0b, want 1 (data %0d)", cmd_ready, data);
    else begin
      n_pass++;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int budget = 300;
    while (rsp_d.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (rsp_d.size() != n) $display("FAIL rsp_count: got %0d, want %0d", rsp_d.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++; if (cmd_ready !== 1'b0)        $display("FAIL rst_cmd_ready: got %0b, want 0", cmd_ready); else n_pass++;
    n_checks++; if (heap_enable !== 1'b0)      $display("FAIL rst_heap_enable: got %0b, want 0", heap_enable); else n_pass++;
    n_checks++; if (heap_operation !== 5'd0)   $display("FAIL rst_heap_op: got %0d, want 0", heap_operation); else n_pass++;
    n_checks++; if (heap_value !== 32'd0)      $display("FAIL rst_heap_value: got %0d, want 0", heap_value); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0)        $display("FAIL rst_rsp_valid: got %0b, want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'd0)        $display("FAIL rst_rsp_data: got %0d, want 0", rsp_data); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0)          $display("FAIL rst_rsp_err: got %0b, want 0", rsp_err); else n_pass++;
    rst_n = 1'b1;
    n_checks++; if (cmd_ready !== 1'b0)        $display("FAIL rst_release_early: got %0b, want 0", cmd_ready); else n_pass++;
    tick();
    n_checks++; if (cmd_ready !== 1'b1)        $display("FAIL rst_release_ready: got %0b, want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_insert_seq();
    int unsigned exp_v[5] = '{15, 10, 20, 5, 30};
    clear_logs();
    rsp_ready = 1'b1;
    send(2'd1, 32'd15);
    send(2'd1, 32'd10);
    send(2'd1, 32'd20);
    send(2'd1, 32'd5);
    send(2'd1, 32'd30);
    wait_rsp(5);
    tick(2);
    n_checks++; if (stb_op.size() != 5) $display("FAIL ins_strobes: got %0d, want 5", stb_op.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (stb_val.size() <= i || stb_val[i] !== exp_v[i] || stb_op[i] !== 1)
        $display("FAIL ins_strobe_%0d: got op %0d val %0d, want op 1 val %0d", i, (stb_op.size() > i) ? stb_op[i] : 0, (stb_val.size() > i) ? stb_val[i] : 0, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (rsp_d.size() <= i || rsp_d[i] !== 0 || rsp_e[i] !== 0)
        $display("FAIL ins_rsp_%0d: got data %0d err %0d, want 0/0", i, (rsp_d.size() > i) ? rsp_d[i] : 0, (rsp_e.size() > i) ? rsp_e[i] : 0);
      else n_pass++;
    end
    n_checks++;
    if (stb_cyc.size() != 5 || stb_cyc[4] - stb_cyc[0] != 24)
      $display("FAIL ins_throughput: got span %0d, want 24", (stb_cyc.size() == 5) ? stb_cyc[4] - stb_cyc[0] : 0);
    else n_pass++;
    n_checks++; if (bad_idle != 0) $display("FAIL ins_idle_outputs: got %0d nonzero cycles, want 0", bad_idle); else n_pass++;
  endtask

  task automatic test_extract_peek();
    clear_logs();
    send(2'd2, 32'd0);
    wait_rsp(1);
    tick(2);
    n_checks++; if (stb_op.size() != 1 || stb_op[0] !== 2) $display("FAIL ext_strobe: got count %0d, want 1 with op 2", stb_op.size()); else n_pass++;
    n_checks++; if (rsp_d[0] !== 5 || rsp_e[0] !== 0) $display("FAIL ext_rsp: got data %0d err %0d, want 5/0", rsp_d[0], rsp_e[0]); else n_pass++;
    clear_logs();
    send(2'd3, 32'd0);
    wait_rsp(1);
    tick(2);
    n_checks++; if (stb_op.size() != 0) $display("FAIL peek_strobe: got %0d, want 0", stb_op.size()); else n_pass++;
    n_checks++; if (rsp_d[0] !== 10 || rsp_e[0] !== 0) $display("FAIL peek_rsp: got data %0d err %0d, want 10/0", rsp_d[0], rsp_e[0]); else n_pass++;
  endtask

  task automatic test_empty();
    int unsigned exp_v[4] = '{10, 15, 20, 30};
    clear_logs();
    repeat (4) send(2'd2, 32'd0);
    wait_rsp(4);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rsp_d[i] !== exp_v[i] || rsp_e[i] !== 0) $display("FAIL drain_%0d: got data %0d err %0d, want %0d/0", i, rsp_d[i], rsp_e[i], exp_v[i]);
      else n_pass++;
    end
    clear_logs();
    send(2'd2, 32'd0);
    send(2'd3, 32'd0);
    send(2'd0, 32'd77);
    wait_rsp(3);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rsp_d[i] !== 0 || rsp_e[i] !== 1) $display("FAIL empty_err_%0d: got data %0d err %0d, want 0/1", i, rsp_d[i], rsp_e[i]);
      else n_pass++;
    end
    n_checks++; if (stb_op.size() != 0) $display("FAIL empty_strobe: got %0d, want 0", stb_op.size()); else n_pass++;
  endtask

  task automatic test_full();
    clear_logs();
    size_ovr_en = 1'b1;
    size_ovr    = 5'd31;
    send(2'd1, 32'd7);
    wait_rsp(1);
    tick(2);
    n_checks++; if (rsp_e[0] !== 1 || rsp_d[0] !== 0) $display("FAIL full_rsp: got data %0d err %0d, want 0/1", rsp_d[0], rsp_e[0]); else n_pass++;
    n_checks++; if (stb_op.size() != 0) $display("FAIL full_strobe: got %0d, want 0", stb_op.size()); else n_pass++;
    clear_logs();
    size_ovr = 5'd30;
    send(2'd1, 32'd7);
    wait_rsp(1);
    tick(2);
    size_ovr_en = 1'b0;
    n_checks++; if (rsp_e[0] !== 0) $display("FAIL below_cap_rsp: got err %0d, want 0", rsp_e[0]); else n_pass++;
    n_checks++; if (stb_val.size() != 1 || stb_val[0] !== 7) $display("FAIL below_cap_strobe: got count %0d, want 1 with value 7", stb_val.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int unsigned exp_d[5] = '{7, 0, 3, 0, 7};
    int unsigned exp_sv[3] = '{3, 0, 8};
    int unsigned exp_so[3] = '{1, 2, 1};
    int ready_seen = 0;
    clear_logs();
    rsp_ready = 1'b0;
    send(2'd3, 32'd0);
    send(2'd1, 32'd3);
    send(2'd2, 32'd0);
    send(2'd1, 32'd8);
    send(2'd3, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 32'd99;
    repeat (4) begin
      if (cmd_ready) ready_seen++;
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++; if (ready_seen != 0) $display("FAIL bp_ready_drop: got %0d ready cycles, want 0", ready_seen); else n_pass++;
    n_checks++; if (rsp_valid !== 1 || rsp_data !== 7 || rsp_err !== 0) $display("FAIL bp_hold_a: got v%0b d%0d e%0b, want v1 d7 e0", rsp_valid, rsp_data, rsp_err); else n_pass++;
    tick(5);
    n_checks++; if (rsp_valid !== 1 || rsp_data !== 7 || rsp_err !== 0) $display("FAIL bp_hold_b: got v%0b d%0d e%0b, want v1 d7 e0", rsp_valid, rsp_data, rsp_err); else n_pass++;
    n_checks++; if (stb_op.size() != 0) $display("FAIL bp_no_strobe: got %0d, want 0", stb_op.size()); else n_pass++;
    rsp_ready = 1'b1;
    wait_rsp(5);
    tick(20);
    n_checks++; if (rsp_d.size() != 5) $display("FAIL bp_rsp_total: got %0d, want 5", rsp_d.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_d[i] !== exp_d[i] || rsp_e[i] !== 0) $display("FAIL bp_rsp_%0d: got data %0d err %0d, want %0d/0", i, rsp_d[i], rsp_e[i], exp_d[i]);
      else n_pass++;
    end
    n_checks++; if (stb_op.size() != 3) $display("FAIL bp_strobes: got %0d, want 3", stb_op.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (stb_op[i] !== exp_so[i] || stb_val[i] !== exp_sv[i])
        $display("FAIL bp_strobe_%0d: got op %0d val %0d, want op %0d val %0d", i, stb_op[i], stb_val[i], exp_so[i], exp_sv[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_wait();
    int budget = 50;
    clear_logs();
    rsp_ready = 1'b1;
    send(2'd2, 32'd0);
    send(2'd1, 32'd41);
    send(2'd1, 32'd42);
    while (!heap_enable && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++; if (heap_enable !== 1'b1) $display("FAIL rw_strobe_seen: got %0b, want 1", heap_enable); else n_pass++;
    tick();
    n_checks++; if (heap_enable !== 0 || rsp_valid !== 0 || rsp_data !== 7) $display("FAIL rw_in_wait: got en%0b v%0b d%0d, want en0 v0 d7", heap_enable, rsp_valid, rsp_data); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 0 || heap_enable !== 0 || heap_operation !== 0 || heap_value !== 0 || rsp_valid !== 0 || rsp_data !== 0 || rsp_err !== 0)
      $display("FAIL rw_outputs_zero: got rdy%0b en%0b op%0d val%0d v%0b d%0d e%0b, want all 0", cmd_ready, heap_enable, heap_operation, heap_value, rsp_valid, rsp_data, rsp_err);
    else n_pass++;
    rst_n = 1'b1;
    clear_logs();
    tick(30);
    n_checks++; if (stb_op.size() != 0 || rsp_d.size() != 0) $display("FAIL rw_discard: got %0d strobes %0d rsps, want 0/0", stb_op.size(), rsp_d.size()); else n_pass++;
    send(2'd1, 32'd9);
    wait_rsp(1);
    tick(2);
    n_checks++; if (rsp_d[0] !== 0 || rsp_e[0] !== 0) $display("FAIL rw_after_rsp: got data %0d err %0d, want 0/0", rsp_d[0], rsp_e[0]); else n_pass++;
    n_checks++; if (stb_op.size() != 1 || stb_op[0] !== 1 || stb_val[0] !== 9) $display("FAIL rw_after_strobe: got count %0d, want 1 with op 1 val 9", stb_op.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_insert_seq();
    test_extract_peek();
    test_empty();
    test_full();
    test_backpressure();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
